// File: rtl/psum_writeback.sv
// Drains partial-sum vectors from the corelet output FIFO into the psum SRAM,
// either overwriting stored sums or accumulating into them with per-lane saturation.
module psum_writeback #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11,
    parameter int num_out = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     acc_mode,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic                     ofifo_valid,
    input  logic [psum_bw*col-1:0]   psum_in,
    output logic                     ofifo_rd,
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [addr_bw-1:0]       sram_addr,
    output logic [psum_bw*col-1:0]   sram_d,
    input  logic [psum_bw*col-1:0]   sram_q,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = (num_out > 1) ? $clog2(num_out) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(num_out - 1);
    localparam logic signed [psum_bw-1:0] PSUM_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw-1:0] PSUM_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, OVR, ACC_RD, ACC_WR, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [addr_bw-1:0]   base;
    logic [addr_bw-1:0]   vec_addr;
    logic [psum_bw*col-1:0] acc_sum;

    // The extra sign bit exposes overflow: the top two bits differ only when the lane sum left range.
    function automatic logic signed [psum_bw-1:0] sat_add(
        input logic signed [psum_bw-1:0] a,
        input logic signed [psum_bw-1:0] b
    );
        logic signed [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (s[psum_bw] != s[psum_bw-1])
            sat_add = s[psum_bw] ? PSUM_MIN : PSUM_MAX;
        else
            sat_add = s[psum_bw-1:0];
    endfunction

    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < col; k++)
            acc_sum[k*psum_bw +: psum_bw] = sat_add(sram_q[k*psum_bw +: psum_bw],
                                                    psum_in[k*psum_bw +: psum_bw]);
    end

    // Address wraps modulo the SRAM size by construction of the addr_bw-wide sum.
    assign vec_addr = base + addr_bw'(cnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            base  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && start)
                base <= base_addr;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ofifo_rd  = 1'b0;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        sram_addr = '0;
        sram_d    = '0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nxt   = '0;
                    state_nxt = acc_mode ? ACC_RD : OVR;
                end
            end
            OVR: begin
                if (ofifo_valid) begin
                    ofifo_rd  = 1'b1;
                    sram_cen  = 1'b0;
                    sram_wen  = 1'b0;
                    sram_addr = vec_addr;
                    sram_d    = psum_in;
                    cnt_nxt   = cnt + 1'b1;
                    if (cnt == LAST)
                        state_nxt = DONE;
                end
            end
            ACC_RD: begin
                if (ofifo_valid) begin
                    sram_cen  = 1'b0;
                    sram_addr = vec_addr;
                    state_nxt = ACC_WR;
                end
            end
            ACC_WR: begin
                // Guarded so a misbehaving FIFO can never be popped while empty.
                if (ofifo_valid) begin
                    ofifo_rd  = 1'b1;
                    sram_cen  = 1'b0;
                    sram_wen  = 1'b0;
                    sram_addr = vec_addr;
                    sram_d    = acc_sum;
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = (cnt == LAST) ? DONE : ACC_RD;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
